// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath defaults and the writeback control
// bundle carried by the ID/EX, EX/MEM and MEM/WB registers.
package pipeline_pkg;

    localparam int DEFAULT_DATA_W     = 32;
    localparam int DEFAULT_REG_ADDR_W = 5;

    localparam logic [DEFAULT_REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                          valid;
        logic                          reg_write;
        logic                          mem_to_reg;
        logic [DEFAULT_REG_ADDR_W-1:0] rd;
    } wb_ctrl_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage boundary: pipeline control, MEM-stage results in,
// register-file write port and retire count out.
interface mem_wb_stage_if #(
    parameter int DATA_W     = pipeline_pkg::DEFAULT_DATA_W,
    parameter int REG_ADDR_W = pipeline_pkg::DEFAULT_REG_ADDR_W,
    parameter int CNT_W      = 32
);
    logic                  stall;
    logic                  flush;
    logic                  in_valid;
    logic                  in_reg_write;
    logic                  in_mem_to_reg;
    logic [REG_ADDR_W-1:0] in_rd;
    logic [DATA_W-1:0]     in_alu_result;
    logic [DATA_W-1:0]     in_read_data;

    logic                  wb_we;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0]     wb_data;
    logic                  wb_valid;
    logic [CNT_W-1:0]      retired_count;

    modport master (
        output stall, flush, in_valid, in_reg_write, in_mem_to_reg,
               in_rd, in_alu_result, in_read_data,
        input  wb_we, wb_rd, wb_data, wb_valid, retired_count
    );

    modport slave (
        input  stall, flush, in_valid, in_reg_write, in_mem_to_reg,
               in_rd, in_alu_result, in_read_data,
        output wb_we, wb_rd, wb_data, wb_valid, retired_count
    );
endinterface

// File: rtl/mem_wb_stage_retire_counter.sv
// Free-running enable counter with asynchronous active-low clear;
// wraps modulo 2^CNT_W.
module retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback select, x0 write suppression,
// stall/flush control and a retired-instruction counter.
module mem_wb_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
    parameter int CNT_W      = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_wb_stage_if.slave  bus
);

    wb_ctrl_t          ctrl_q;
    wb_ctrl_t          ctrl_d;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] rdata_q;
    logic              retire_en;

    // NOTE: combinational blocks assign every output a default first, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        ctrl_d            = '0;
        ctrl_d.valid      = bus.in_valid;
        ctrl_d.reg_write  = bus.in_reg_write;
        ctrl_d.mem_to_reg = bus.in_mem_to_reg;
        ctrl_d.rd         = bus.in_rd;
    end

    // Priority flush > stall > capture; a flush leaves an all-zero bubble.
    // NOTE: every pipeline field is reset, not only valid, so a cleared
    // stage never exposes stale data on the forwarding path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            alu_q   <= '0;
            rdata_q <= '0;
        end else if (bus.flush) begin
            ctrl_q  <= '0;
            alu_q   <= '0;
            rdata_q <= '0;
        end else if (!bus.stall) begin
            ctrl_q  <= ctrl_d;
            alu_q   <= bus.in_alu_result;
            rdata_q <= bus.in_read_data;
        end
    end

    // The held instruction retires whenever it leaves WB, including by flush.
    assign retire_en = ctrl_q.valid & (bus.flush | ~bus.stall);

    retire_counter #(
        .CNT_W (CNT_W)
    ) u_retire_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (retire_en),
        .count (bus.retired_count)
    );

    assign bus.wb_data  = ctrl_q.mem_to_reg ? rdata_q : alu_q;
    assign bus.wb_we    = ctrl_q.valid & ctrl_q.reg_write & (ctrl_q.rd != REG_ZERO);
    assign bus.wb_rd    = ctrl_q.rd;
    assign bus.wb_valid = ctrl_q.valid;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage, including a 4-bit counter
// build for the wrap case.
module tb_mem_wb_stage;

    logic clk;
    logic rst_n;

    int tests_run;
    int tests_failed;

    mem_wb_stage_if #(.CNT_W(32)) bus ();
    mem_wb_stage_if #(.CNT_W(4))  bus4 ();

    mem_wb_stage #(.CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mem_wb_stage #(.CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic rw, input logic m2r,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdata);
        bus.in_valid      = valid;
        bus.in_reg_write  = rw;
        bus.in_mem_to_reg = m2r;
        bus.in_rd         = rd;
        bus.in_alu_result = alu;
        bus.in_read_data  = rdata;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        bus4.stall         = 1'b0;
        bus4.flush         = 1'b0;
        bus4.in_valid      = 1'b0;
        bus4.in_reg_write  = 1'b0;
        bus4.in_mem_to_reg = 1'b0;
        bus4.in_rd         = 5'd0;
        bus4.in_alu_result = 32'h0;
        bus4.in_read_data  = 32'h0;

        #12 rst_n = 1'b1;
        check("rst_we",    {63'd0, bus.wb_we},    64'd0);
        check("rst_valid", {63'd0, bus.wb_valid}, 64'd0);
        check("rst_count", {32'd0, bus.retired_count}, 64'd0);

        // Load writeback, then ALU writeback
        drive(1'b1, 1'b1, 1'b1, 5'd5, 32'h10, 32'hDEADBEEF);
        step();
        check("ld_we",    {63'd0, bus.wb_we},     64'd1);
        check("ld_rd",    {59'd0, bus.wb_rd},     64'd5);
        check("ld_data",  {32'd0, bus.wb_data},   64'hDEADBEEF);
        check("ld_count", {32'd0, bus.retired_count}, 64'd0);
        drive(1'b1, 1'b1, 1'b0, 5'd5, 32'h10, 32'hDEADBEEF);
        step();
        check("alu_data",  {32'd0, bus.wb_data},  64'h10);
        check("alu_count", {32'd0, bus.retired_count}, 64'd1);

        // x0 destination: valid but no write
        drive(1'b1, 1'b1, 1'b0, 5'd0, 32'h1234, 32'h0);
        step();
        check("x0_we",    {63'd0, bus.wb_we},    64'd0);
        check("x0_valid", {63'd0, bus.wb_valid}, 64'd1);
        check("x0_data",  {32'd0, bus.wb_data},  64'h1234);
        check("x0_count", {32'd0, bus.retired_count}, 64'd2);

        // Bubble with reg_write set
        drive(1'b0, 1'b1, 1'b0, 5'd7, 32'h55, 32'h0);
        step();
        check("bub_count", {32'd0, bus.retired_count}, 64'd3);
        check("bub_we",    {63'd0, bus.wb_we},    64'd0);
        check("bub_valid", {63'd0, bus.wb_valid}, 64'd0);

        // Stall for 3 cycles while inputs change
        drive(1'b1, 1'b1, 1'b0, 5'd9, 32'hAAAA, 32'h0);
        step();
        check("pre_stall_count", {32'd0, bus.retired_count}, 64'd3);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'(i % 2), 5'(20 + i), 32'h100 + i, 32'h200 + i);
            step();
            check("stall_rd",    {59'd0, bus.wb_rd},   64'd9);
            check("stall_data",  {32'd0, bus.wb_data}, 64'hAAAA);
            check("stall_we",    {63'd0, bus.wb_we},   64'd1);
            check("stall_count", {32'd0, bus.retired_count}, 64'd3);
        end
        bus.stall = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 5'd3, 32'hBBBB, 32'h0);
        step();
        check("unstall_count", {32'd0, bus.retired_count}, 64'd4);
        check("unstall_rd",    {59'd0, bus.wb_rd},   64'd3);

        // Stall and flush together: flush wins, outgoing counted once
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        step();
        check("flush_valid", {63'd0, bus.wb_valid}, 64'd0);
        check("flush_we",    {63'd0, bus.wb_we},    64'd0);
        check("flush_data",  {32'd0, bus.wb_data},  64'd0);
        check("flush_count", {32'd0, bus.retired_count}, 64'd5);
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 5'd4, 32'hCCCC, 32'h0);
        step();
        check("post_flush_count", {32'd0, bus.retired_count}, 64'd5);
        check("post_flush_data",  {32'd0, bus.wb_data},  64'hCCCC);

        // Asynchronous reset mid-cycle with a valid instruction held
        #2 rst_n = 1'b0;
        #1;
        check("arst_we",    {63'd0, bus.wb_we},    64'd0);
        check("arst_valid", {63'd0, bus.wb_valid}, 64'd0);
        check("arst_data",  {32'd0, bus.wb_data},  64'd0);
        check("arst_count", {32'd0, bus.retired_count}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 4-bit counter: 17 back-to-back valid instructions
        bus4.in_valid     = 1'b1;
        bus4.in_reg_write = 1'b1;
        bus4.in_rd        = 5'd1;
        for (int i = 0; i < 17; i++) begin
            bus4.in_alu_result = 32'(i);
            step();
        end
        check("wrap_mid_count", {60'd0, bus4.retired_count}, 64'd0);
        bus4.in_valid = 1'b0;
        step();
        check("wrap_count", {60'd0, bus4.retired_count}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
